// File: rtl/jt900h_dmp_rd.sv
// jt900h_dmp_rd
// Reads the jt900h register-dump port in hardware and streams the captured
// bytes out over a valid/ready byte interface. This replaces the
// simulation-only dump logic.
//
// A dump is triggered by either of two events:
//   - a single-cycle start pulse, or
//   - the CPU writing the upper byte of STOP_ADDR.
// When triggered, the block halts the CPU, walks dmp_addr from 0 to
// DUMP_LEN-1 and forwards each byte it captures. After the last byte it
// stays in DONE, with the CPU still halted, until the next reset.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   cpu_addr  in   CPU bus address (24 bits)
//   cpu_we    in   CPU byte write enables, bit 1 = upper byte
//   start     in   external dump request, single-cycle pulse
//   cpu_cen   out  CPU clock enable, 0 halts the CPU
//   dmp_addr  out  dump port address (8 bits)
//   dmp_dout  in   dump port data, valid one clock after dmp_addr changes
//   st_data   out  stream byte
//   st_valid  out  stream byte valid
//   st_ready  in   sink accepts the byte
//   st_last   out  marks byte DUMP_LEN-1
//   busy      out  dump in progress
//   done      out  dump complete, sticky until reset
module jt900h_dmp_rd #(
   parameter int          DUMP_LEN  = 84,
   parameter logic [23:0] STOP_ADDR = 24'hffff
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] cpu_addr,
   input  logic [1:0]  cpu_we,
   input  logic        start,
   output logic        cpu_cen,
   output logic [7:0]  dmp_addr,
   input  logic [7:0]  dmp_dout,
   output logic [7:0]  st_data,
   output logic        st_valid,
   input  logic        st_ready,
   output logic        st_last,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] LAST_IDX = 8'(DUMP_LEN - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      FETCH = 3'd2,
      SEND  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t     state_q;
   logic       cpu_cen_q;
   logic [7:0] dmp_addr_q;
   logic [7:0] st_data_q;
   logic       st_valid_q;
   logic       st_last_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] idx_q;

   logic       trig_d;
   logic       is_last_d;
   logic [7:0] idx_d;

   // Only a write to the upper byte of STOP_ADDR counts as the CPU stop signal.
   assign trig_d    = start | (cpu_we[1] & (cpu_addr == STOP_ADDR));
   assign is_last_d = (idx_q == LAST_IDX);
   // The counter never wraps: the step to idx_q+1 only happens below LAST_IDX.
   assign idx_d     = idx_q + 8'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cpu_cen_q  <= 1'b1;
         dmp_addr_q <= 8'd0;
         st_data_q  <= 8'd0;
         st_valid_q <= 1'b0;
         st_last_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         idx_q      <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trig_d) begin
                  state_q    <= HALT;
                  cpu_cen_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  dmp_addr_q <= 8'd0;
                  idx_q      <= 8'd0;
               end
            end
            // Give the halted CPU one cycle to settle before the first read.
            HALT: state_q <= FETCH;
            // dmp_addr has been stable for a full cycle, so dmp_dout is valid here.
            FETCH: begin
               st_data_q  <= dmp_dout;
               st_valid_q <= 1'b1;
               st_last_q  <= is_last_d;
               state_q    <= SEND;
            end
            // Data and last stay frozen until the sink takes the byte.
            SEND: begin
               if (st_ready) begin
                  st_valid_q <= 1'b0;
                  if (is_last_d) begin
                     st_last_q <= 1'b0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     idx_q      <= idx_d;
                     dmp_addr_q <= idx_d;
                     state_q    <= FETCH;
                  end
               end
            end
            // Terminal state: the CPU stays halted and triggers are ignored.
            DONE: state_q <= DONE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_cen  = cpu_cen_q;
   assign dmp_addr = dmp_addr_q;
   assign st_data  = st_data_q;
   assign st_valid = st_valid_q;
   assign st_last  = st_last_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_jt900h_dmp_rd.sv
module tb_jt900h_dmp_rd;
   localparam int N = 84;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [23:0] cpu_addr;
   logic [1:0]  cpu_we;
   logic        start;
   logic        cpu_cen;
   logic [7:0]  dmp_addr;
   logic [7:0]  dmp_dout;
   logic [7:0]  st_data;
   logic        st_valid;
   logic        st_ready;
   logic        st_last;
   logic        busy;
   logic        done;

   // second instance, DUMP_LEN = 1
   logic [23:0] cpu_addr1;
   logic [1:0]  cpu_we1;
   logic        start1, cpu_cen1, st_valid1, st_ready1, st_last1, busy1, done1;
   logic [7:0]  dmp_addr1, dmp_dout1, st_data1;

   // dump port memory: each address holds addr ^ 5A
   assign dmp_dout  = dmp_addr ^ 8'h5A;
   assign dmp_dout1 = dmp_addr1 ^ 8'h5A;

   jt900h_dmp_rd #(.DUMP_LEN(N), .STOP_ADDR(24'hffff)) dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .start(start),
      .cpu_cen(cpu_cen), .dmp_addr(dmp_addr), .dmp_dout(dmp_dout),
      .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
      .st_last(st_last), .busy(busy), .done(done));

   jt900h_dmp_rd #(.DUMP_LEN(1), .STOP_ADDR(24'hffff)) dut1 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr1), .cpu_we(cpu_we1), .start(start1),
      .cpu_cen(cpu_cen1), .dmp_addr(dmp_addr1), .dmp_dout(dmp_dout1),
      .st_data(st_data1), .st_valid(st_valid1), .st_ready(st_ready1),
      .st_last(st_last1), .busy(busy1), .done(done1));

   int n_tests = 0;
   int n_fail  = 0;
   int el;
   bit tmo;

   // stream monitor: records every handshake and flags any stalled byte
   // that changes or disappears before it is accepted
   logic [7:0] got_q[$];
   logic       got_last[$];
   int         stall_viol;
   int         max_addr;
   bit         prev_stall;
   logic [7:0] prev_data;
   logic       prev_last;

   always @(posedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!st_valid || st_data !== prev_data || st_last !== prev_last))
            stall_viol++;
         if (st_valid && st_ready) begin
            got_q.push_back(st_data);
            got_last.push_back(st_last);
         end
         if (int'(dmp_addr) > max_addr) max_addr = int'(dmp_addr);
         prev_stall = st_valid && !st_ready;
         prev_data  = st_data;
         prev_last  = st_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      got_last.delete();
      stall_viol = 0;
      max_addr   = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      cpu_addr = 24'h0; cpu_we = 2'b00; start = 1'b0; st_ready = 1'b0;
      cpu_addr1 = 24'h0; cpu_we1 = 2'b00; start1 = 1'b0; st_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      clear_mon();
   endtask

   // run until done (or budget edges), counting edges in el
   task automatic run_until_done(input int budget, input bit rand_ready);
      tmo = 1'b1;
      for (int i = 0; i < budget; i++) begin
         st_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         el++;
         if (done) begin
            tmo = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++; if (cpu_cen !== 1'b1) begin n_fail++; $display("FAIL rst_cen: got %b want 1", cpu_cen); end
      n_tests++; if (dmp_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", dmp_addr); end
      n_tests++; if (st_data !== 8'h00 || st_valid !== 1'b0 || st_last !== 1'b0) begin
         n_fail++; $display("FAIL rst_stream: got d=%h v=%b l=%b want 00/0/0", st_data, st_valid, st_last); end
      n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL rst_flags: got busy=%b done=%b want 0/0", busy, done); end
      repeat (3) tick();
      n_tests++; if (cpu_cen !== 1'b1 || busy !== 1'b0 || st_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_hold: got cen=%b busy=%b v=%b want 1/0/0", cpu_cen, busy, st_valid); end
   endtask

   task automatic test_start();
      int bad;
      apply_reset();
      st_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      el = 0;
      n_tests++; if (cpu_cen !== 1'b0 || busy !== 1'b1 || st_valid !== 1'b0) begin
         n_fail++; $display("FAIL trig_edge: got cen=%b busy=%b v=%b want 0/1/0", cpu_cen, busy, st_valid); end
      tick(); el++;
      n_tests++; if (st_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b want 0", st_valid); end
      tick(); el++;
      n_tests++; if (st_valid !== 1'b1 || st_data !== 8'h5A || st_last !== 1'b0) begin
         n_fail++; $display("FAIL first_byte: got v=%b d=%h l=%b want 1/5a/0", st_valid, st_data, st_last); end
      run_until_done(400, 1'b0);
      n_tests++; if (tmo || el != 2 * N + 1) begin
         n_fail++; $display("FAIL done_time: got %0d edges (timeout=%0b) want %0d", el, tmo, 2 * N + 1); end
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] !== (8'(k) ^ 8'h5A) || got_last[k] !== (k == N - 1)) bad++;
      n_tests++; if (got_q.size() != N || bad != 0) begin
         n_fail++; $display("FAIL start_bytes: got %0d bytes %0d bad want %0d bytes 0 bad", got_q.size(), bad, N); end
      n_tests++; if (max_addr > N - 1) begin n_fail++; $display("FAIL max_addr: got %0d want <= %0d", max_addr, N - 1); end
      repeat (5) tick();
      n_tests++; if (cpu_cen !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || st_valid !== 1'b0) begin
         n_fail++; $display("FAIL after_done: got cen=%b done=%b busy=%b v=%b want 0/1/0/0", cpu_cen, done, busy, st_valid); end
   endtask

   task automatic test_stop();
      int bad;
      apply_reset();
      st_ready = 1'b1;
      cpu_addr = 24'hffff; cpu_we = 2'b01;
      tick();
      cpu_we = 2'b00;
      tick();
      n_tests++; if (cpu_cen !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL lower_we: got cen=%b busy=%b want 1/0", cpu_cen, busy); end
      cpu_addr = 24'hfffe; cpu_we = 2'b10;
      tick();
      cpu_we = 2'b00;
      tick();
      n_tests++; if (cpu_cen !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL wrong_addr: got cen=%b busy=%b want 1/0", cpu_cen, busy); end
      cpu_addr = 24'hffff; cpu_we = 2'b10;
      tick();
      cpu_we = 2'b00;
      el = 0;
      n_tests++; if (cpu_cen !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL stop_trig: got cen=%b busy=%b want 0/1", cpu_cen, busy); end
      run_until_done(400, 1'b0);
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] !== (8'(k) ^ 8'h5A) || got_last[k] !== (k == N - 1)) bad++;
      n_tests++; if (tmo || el != 2 * N + 1 || got_q.size() != N || bad != 0) begin
         n_fail++; $display("FAIL stop_dump: got %0d edges %0d bytes %0d bad want %0d/%0d/0", el, got_q.size(), bad, 2 * N + 1, N); end
   endtask

   task automatic test_random_ready();
      int bad;
      apply_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      el = 0;
      run_until_done(3000, 1'b1);
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] !== (8'(k) ^ 8'h5A) || got_last[k] !== (k == N - 1)) bad++;
      n_tests++; if (tmo || got_q.size() != N || bad != 0) begin
         n_fail++; $display("FAIL rand_bytes: got %0d bytes %0d bad timeout=%0b want %0d/0/0", got_q.size(), bad, tmo, N); end
      n_tests++; if (stall_viol != 0) begin
         n_fail++; $display("FAIL stall_hold: got %0d violations want 0", stall_viol); end
   endtask

   task automatic test_back_to_back_triggers();
      int bad;
      apply_reset();
      st_ready = 1'b1;
      start = 1'b1; cpu_addr = 24'hffff; cpu_we = 2'b10;
      tick();
      start = 1'b0; cpu_we = 2'b00;
      el = 0;
      tmo = 1'b1;
      for (int i = 0; i < 400; i++) begin
         start  = (got_q.size() == 10 || got_q.size() == 40);
         cpu_we = (got_q.size() == 5) ? 2'b10 : 2'b00;
         tick();
         el++;
         start = 1'b0; cpu_we = 2'b00;
         if (done) begin tmo = 1'b0; break; end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] !== (8'(k) ^ 8'h5A) || got_last[k] !== (k == N - 1)) bad++;
      n_tests++; if (tmo || el != 2 * N + 1 || got_q.size() != N || bad != 0) begin
         n_fail++; $display("FAIL retrig_dump: got %0d edges %0d bytes %0d bad want %0d/%0d/0", el, got_q.size(), bad, 2 * N + 1, N); end
      n_tests++; if (done !== 1'b1 || busy !== 1'b0 || cpu_cen !== 1'b0) begin
         n_fail++; $display("FAIL retrig_done: got done=%b busy=%b cen=%b want 1/0/0", done, busy, cpu_cen); end
   endtask

   task automatic test_reset_mid();
      int bad;
      apply_reset();
      st_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (got_q.size() >= 20) st_ready = 1'b0;
         tick();
         if (got_q.size() == 20 && st_valid) begin tmo = 1'b0; break; end
      end
      n_tests++; if (tmo || st_data !== (8'd20 ^ 8'h5A)) begin
         n_fail++; $display("FAIL mid_byte: got d=%h timeout=%0b want %h/0", st_data, tmo, 8'd20 ^ 8'h5A); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if (cpu_cen !== 1'b1 || st_valid !== 1'b0 || st_last !== 1'b0 || st_data !== 8'h00 ||
                     dmp_addr !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: got cen=%b v=%b l=%b d=%h a=%h busy=%b done=%b want 1/0/0/00/00/0/0",
                            cpu_cen, st_valid, st_last, st_data, dmp_addr, busy, done); end
      @(posedge clk);
      #1 rst = 1'b1;
      clear_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      el = 0;
      run_until_done(400, 1'b0);
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] !== (8'(k) ^ 8'h5A) || got_last[k] !== (k == N - 1)) bad++;
      n_tests++; if (tmo || got_q.size() != N || bad != 0) begin
         n_fail++; $display("FAIL redump: got %0d bytes %0d bad timeout=%0b want %0d/0/0", got_q.size(), bad, tmo, N); end
   endtask

   task automatic test_len1();
      int  v_el;
      bit  seen;
      logic [7:0] v_data;
      logic v_last;
      apply_reset();
      st_ready1 = 1'b1;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      el = 0; seen = 1'b0; v_el = -1; v_data = 8'h00; v_last = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         el++;
         if (st_valid1 && !seen) begin seen = 1'b1; v_el = el; v_data = st_data1; v_last = st_last1; end
         if (done1) begin tmo = 1'b0; break; end
      end
      n_tests++; if (v_el != 2 || v_data !== 8'h5A || v_last !== 1'b1) begin
         n_fail++; $display("FAIL len1_byte: got edge=%0d d=%h l=%b want 2/5a/1", v_el, v_data, v_last); end
      n_tests++; if (tmo || el != 3 || cpu_cen1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL len1_done: got edge=%0d cen=%b busy=%b want 3/0/0", el, cpu_cen1, busy1); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_stop();
      test_random_ready();
      test_back_to_back_triggers();
      test_reset_mid();
      test_len1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
